// File: rtl/crc16_frame_ctrl.sv
// Frame serializer: shifts payload bytes out MSB first, then the 16-bit CRC from an external engine.
// Also holds the bit-serial CRC16 engine (poly 0x1021) that the controller drives.

module crc16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reload,
    input  logic        valid,
    input  logic        data,
    input  logic        shift,
    output logic [15:0] crc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'hffff;
        end else if (reload) begin
            crc <= 16'hffff;
        end else if (valid) begin
            // shift mode drains the register with no feedback so its MSB can be transmitted
            if (shift)
                crc <= {crc[14:0], 1'b0};
            else
                crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ data) ? 16'h1021 : 16'h0000);
        end
    end
endmodule

module crc16_frame_ctrl #(
    parameter bit CRC_INV = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_bit_valid,
    output logic        o_bit,
    input  logic        i_bit_ready,
    output logic        o_reload_crc,
    output logic        o_valid_crc,
    output logic        o_data_crc,
    output logic        o_shift_crc,
    input  logic [15:0] i_crc,
    output logic        o_busy,
    output logic        o_done
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] WAIT_BYTE = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] CRC       = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    logic [2:0] state;
    logic [7:0] shreg;
    logic [3:0] cnt;
    logic       last;
    logic       take_byte;
    logic       take_bit;

    // Abort gates the handshakes in the same cycle so nothing is consumed while leaving.
    always_comb begin
        o_busy       = (state != IDLE);
        o_ready      = (state == WAIT_BYTE) && !i_abort;
        o_bit_valid  = ((state == SEND) || (state == CRC)) && !i_abort;
        o_bit        = 1'b0;
        if (state == SEND)
            o_bit = shreg[7];
        else if (state == CRC)
            o_bit = i_crc[15] ^ CRC_INV;
        take_byte    = o_ready && i_valid;
        take_bit     = o_bit_valid && i_bit_ready;
        o_valid_crc  = take_bit;
        o_data_crc   = (state == SEND) && shreg[7];
        o_shift_crc  = (state == CRC) && take_bit;
        o_reload_crc = (state == LOAD);
        o_done       = (state == DONE) && !i_abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= 8'h00;
            cnt   <= 4'd0;
            last  <= 1'b0;
        end else if (i_abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start)
                        state <= LOAD;
                end
                LOAD: begin
                    state <= WAIT_BYTE;
                end
                WAIT_BYTE: begin
                    if (take_byte) begin
                        shreg <= i_data;
                        last  <= i_last;
                        cnt   <= 4'd0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (take_bit) begin
                        shreg <= {shreg[6:0], 1'b0};
                        if (cnt == 4'd7) begin
                            cnt   <= 4'd0;
                            state <= last ? CRC : WAIT_BYTE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                CRC: begin
                    if (take_bit) begin
                        if (cnt == 4'd15) begin
                            cnt   <= 4'd0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Directed bench for crc16_frame_ctrl: two controllers (CRC_INV=1 and 0) share stimulus,
// each driving its own crc16 engine.

module tb_crc16_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort, i_valid, i_last, i_bit_ready;
    logic [7:0]  i_data;
    logic        ready1, bv1, bit1, reload1, vcrc1, dcrc1, shift1, busy1, done1;
    logic        ready0, bv0, bit0, reload0, vcrc0, dcrc0, shift0, busy0, done0;
    logic [15:0] crcr1, crcr0;

    always #5 clk = ~clk;

    crc16_frame_ctrl #(.CRC_INV(1'b1)) dut1 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_valid(i_valid),
        .i_data(i_data), .i_last(i_last), .o_ready(ready1), .o_bit_valid(bv1), .o_bit(bit1),
        .i_bit_ready(i_bit_ready), .o_reload_crc(reload1), .o_valid_crc(vcrc1),
        .o_data_crc(dcrc1), .o_shift_crc(shift1), .i_crc(crcr1), .o_busy(busy1), .o_done(done1));
    crc16 eng1 (.clk(clk), .rst_n(~rst), .reload(reload1), .valid(vcrc1), .data(dcrc1),
        .shift(shift1), .crc(crcr1));

    crc16_frame_ctrl #(.CRC_INV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_valid(i_valid),
        .i_data(i_data), .i_last(i_last), .o_ready(ready0), .o_bit_valid(bv0), .o_bit(bit0),
        .i_bit_ready(i_bit_ready), .o_reload_crc(reload0), .o_valid_crc(vcrc0),
        .o_data_crc(dcrc0), .o_shift_crc(shift0), .i_crc(crcr0), .o_busy(busy0), .o_done(done0));
    crc16 eng0 (.clk(clk), .rst_n(~rst), .reload(reload0), .valid(vcrc0), .data(dcrc0),
        .shift(shift0), .crc(crcr0));

    int total = 0;
    int bad   = 0;

    logic [71:0] pay;
    logic [15:0] crc_a, crc_b;
    int ncrc, dones, reloads, inv_err, stab_err, done_cyc, first_cyc;
    bit aborted, abort_leak, timed_out, post_busy;

    typedef struct {
        string       name;
        logic [71:0] b;
        int          n;
        bit          stall;
        logic [15:0] c1;
        logic [15:0] c0;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_start = 1'b0; i_abort = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        i_data = 8'h00; i_bit_ready = 1'b0;
    endtask

    // One frame: bytes are left-justified in b, n of them; abort_at >= 0 aborts after that many CRC bits.
    task automatic run_frame(input logic [71:0] b, input int n, input bit stall,
                             input bit hold_start, input int abort_at);
        int  bidx = 0;
        int  nbits = 0;
        bit  prev_stall = 1'b0;
        logic prev_bit = 1'b0;
        bit  fin = 1'b0;
        pay = '0; crc_a = '0; crc_b = '0;
        ncrc = 0; dones = 0; reloads = 0; inv_err = 0; stab_err = 0;
        done_cyc = -1; first_cyc = -1;
        aborted = 1'b0; abort_leak = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            i_start     = hold_start || (cyc == 0);
            i_valid     = (bidx < n);
            i_data      = 8'h00;
            if (bidx < n)
                i_data = b[71 - 8*bidx -: 8];
            i_last      = (bidx == n - 1);
            i_bit_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_abort     = (abort_at >= 0) && (nbits >= 8*n) && (ncrc == abort_at);
            #1;
            if (prev_stall && (!bv1 || bit1 !== prev_bit)) stab_err++;
            if (reload1 && vcrc1) inv_err++;
            if (shift1 && !(bv1 && nbits >= 8*n)) inv_err++;
            if (vcrc1 && !bv1) inv_err++;
            if (done0 !== done1 || ready0 !== ready1) inv_err++;
            if (reload1) reloads++;
            if (i_abort) begin
                aborted    = 1'b1;
                abort_leak = bv1 | bv0 | vcrc1 | vcrc0 | ready1 | done1;
                fin        = 1'b1;
            end
            if (ready1 && i_valid) bidx++;
            if (bv1 && i_bit_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (nbits < 8*n) begin
                    pay = {pay[70:0], bit1};
                end else begin
                    crc_a = {crc_a[14:0], bit1};
                    crc_b = {crc_b[14:0], bit0};
                    ncrc++;
                end
                nbits++;
            end
            prev_stall = bv1 && !i_bit_ready;
            prev_bit   = bit1;
            if (done1) begin
                dones++;
                done_cyc = cyc;
                fin = 1'b1;
            end
        end
        timed_out = !fin;
        @(negedge clk);
        idle_inputs();
        #1;
        post_busy = busy1 | busy0;
        if (done1) dones++;
    endtask

    initial begin
        vecs[0] = '{"str9",  72'h313233343536373839, 9, 1'b0, 16'hD64E, 16'h29B1};
        vecs[1] = '{"byte00", 72'h000000000000000000, 1, 1'b0, 16'h1E0F, 16'hE1F0};
        vecs[2] = '{"byteff", 72'hFF0000000000000000, 1, 1'b0, 16'h00FF, 16'hFF00};
        vecs[3] = '{"stall9", 72'h313233343536373839, 9, 1'b1, 16'hD64E, 16'h29B1};

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", 72'({ready1, bv1, bit1, reload1, vcrc1, dcrc1, shift1, busy1, done1}), 72'h0);
        check("reset_engine", 72'(crcr1), 72'hFFFF);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].b, vecs[i].n, vecs[i].stall, 1'b0, -1);
            check({vecs[i].name, "_timeout"}, 72'(timed_out), 72'h0);
            check({vecs[i].name, "_payload"}, pay, vecs[i].b >> (72 - 8*vecs[i].n));
            check({vecs[i].name, "_crc_inv1"}, 72'(crc_a), 72'(vecs[i].c1));
            check({vecs[i].name, "_crc_inv0"}, 72'(crc_b), 72'(vecs[i].c0));
            check({vecs[i].name, "_crc_bits"}, 72'(ncrc), 72'd16);
            check({vecs[i].name, "_dones"}, 72'(dones), 72'd1);
            check({vecs[i].name, "_reloads"}, 72'(reloads), 72'd1);
            check({vecs[i].name, "_invariants"}, 72'(inv_err), 72'd0);
            check({vecs[i].name, "_stall_hold"}, 72'(stab_err), 72'd0);
            check({vecs[i].name, "_post_busy"}, 72'(post_busy), 72'd0);
            if (!vecs[i].stall) begin
                check({vecs[i].name, "_first_bit_cyc"}, 72'(first_cyc), 72'd3);
                check({vecs[i].name, "_done_cyc"}, 72'(done_cyc), 72'(9*vecs[i].n + 18));
            end
        end

        // Abort after 5 CRC bits: outputs drop at once, no done ever follows.
        run_frame(vecs[0].b, 9, 1'b0, 1'b0, 5);
        check("abort_seen", 72'(aborted), 72'd1);
        check("abort_outputs", 72'(abort_leak), 72'd0);
        check("abort_post_busy", 72'(post_busy), 72'd0);
        begin
            int late_done = dones;
            repeat (4) begin
                @(negedge clk);
                #1;
                if (done1) late_done++;
            end
            check("abort_no_done", 72'(late_done), 72'd0);
        end
        run_frame(vecs[0].b, 9, 1'b0, 1'b0, -1);
        check("after_abort_crc", 72'(crc_a), 72'hD64E);
        check("after_abort_dones", 72'(dones), 72'd1);

        // Start together with abort in IDLE must not begin a frame.
        @(negedge clk);
        i_start = 1'b1; i_abort = 1'b1;
        #1;
        check("start_abort_idle_reload", 72'(reload1), 72'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("start_abort_idle_busy", 72'({busy1, reload1}), 72'd0);

        // Reset pulse in SEND, asserted between clock edges.
        @(negedge clk);
        i_start = 1'b1; i_valid = 1'b1; i_data = 8'hA5; i_last = 1'b0; i_bit_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_send", 72'({busy1, bv1}), 72'h3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outs", 72'({busy1, bv1, vcrc1, ready1, bit1, done1}), 72'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        run_frame(vecs[0].b, 9, 1'b0, 1'b1, -1);
        check("post_rst_crc", 72'(crc_a), 72'hD64E);
        check("post_rst_reloads", 72'(reloads), 72'd1);
        check("post_rst_dones", 72'(dones), 72'd1);
        check("post_rst_timeout", 72'(timed_out), 72'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
